// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 nibble mux, with a valid/ready
// output handshake and a transfer counter. Define MUX_ARB_PRIO_EN to give channel 0 strict priority.
module mux_rr_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {found, index}: first requester after 'last', wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    logic [2:0] base;
    dbl  = {r, r};
    base = 3'd1 + {1'b0, last};
    rot  = dbl[base +: 4];
    if (rot[0]) begin
      off = 2'd0;
    end else if (rot[1]) begin
      off = 2'd1;
    end else if (rot[2]) begin
      off = 2'd2;
    end else begin
      off = 2'd3;
    end
`ifdef MUX_ARB_PRIO_EN
    if (r[0]) begin
      rr_pick = {1'b1, 2'b00};
    end else begin
      rr_pick = {|rot, last + 2'd1 + off};
    end
`else
    rr_pick = {|rot, last + 2'd1 + off};
`endif
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  logic             state_r;
  logic             state_n_s;
  logic [1:0]       last_r;
  logic [1:0]       last_n_s;
  logic [1:0]       sel_r;
  logic [1:0]       sel_n_s;
  logic [3:0]       grant_r;
  logic [3:0]       grant_n_s;
  logic             valid_r;
  logic             valid_n_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_n_s;
  logic [1:0]       arb_last_s;
  logic [2:0]       pick_s;
  logic             handshake_s;

  // Arbitration starting point: last served in IDLE, the current selection at a handshake.
  always_comb begin
    handshake_s = valid_r & out_ready;
    if (state_r == STATE_GRANT) begin
      arb_last_s = sel_r;
    end else begin
      arb_last_s = last_r;
    end
    pick_s = rr_pick(req, arb_last_s);
  end

  // Next-state logic; GRANT holds everything stable until the handshake.
  always_comb begin
    state_n_s = state_r;
    last_n_s  = last_r;
    sel_n_s   = sel_r;
    grant_n_s = grant_r;
    valid_n_s = valid_r;
    count_n_s = count_r;
    case (state_r)
      STATE_IDLE: begin
        if (pick_s[2]) begin
          state_n_s = STATE_GRANT;
          sel_n_s   = pick_s[1:0];
          grant_n_s = onehot(pick_s[1:0]);
          valid_n_s = 1'b1;
        end else begin
          grant_n_s = 4'b0000;
          valid_n_s = 1'b0;
        end
      end
      STATE_GRANT: begin
        if (handshake_s) begin
          last_n_s  = sel_r;
          count_n_s = count_r + CNT_ONE;
          if (pick_s[2]) begin
            sel_n_s   = pick_s[1:0];
            grant_n_s = onehot(pick_s[1:0]);
            valid_n_s = 1'b1;
          end else begin
            state_n_s = STATE_IDLE;
            grant_n_s = 4'b0000;
            valid_n_s = 1'b0;
          end
        end else begin
          valid_n_s = 1'b1;
        end
      end
      default: begin
        state_n_s = STATE_IDLE;
        grant_n_s = 4'b0000;
        valid_n_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any pending grant without counting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= STATE_IDLE;
      last_r  <= 2'b11;
      sel_r   <= 2'b00;
      grant_r <= 4'b0000;
      valid_r <= 1'b0;
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_n_s;
      last_r  <= last_n_s;
      sel_r   <= sel_n_s;
      grant_r <= grant_n_s;
      valid_r <= valid_n_s;
      count_r <= count_n_s;
    end
  end

  assign grant      = grant_r;
  assign sel        = sel_r;
  assign out_valid  = valid_r;
  assign xfer_count = count_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus random traffic,
// compared each cycle against a transaction-level reference model.
module tb_mux_rr_arbiter;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] xfer_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: busy flag, current selection, last served, total transfers.
  bit busy;
  int msel;
  int mlast;
  int mcount;

  mux_rr_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int last);
`ifdef MUX_ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("sel", {30'd0, sel}, msel);
    chk("grant", {28'd0, grant}, busy ? (32'd1 << msel) : 32'd0);
    chk("out_valid", {31'd0, out_valid}, {31'd0, busy});
    chk("xfer_count", {24'd0, xfer_count}, mcount % (1 << CNT_W));
  endtask

  task automatic model_reset();
    busy = 1'b0; msel = 0; mlast = 3; mcount = 0;
  endtask

  // One clock: drive inputs, advance the model, check just after the edge.
  task automatic step(input logic [3:0] r, input logic rdy);
    req = r;
    out_ready = rdy;
    if (!busy) begin
      if (r != 4'd0) begin
        msel = pick(r, mlast);
        busy = 1'b1;
      end
    end else if (rdy) begin
      mlast = msel;
      mcount++;
      if (r != 4'd0) msel = pick(r, mlast);
      else busy = 1'b0;
    end
    @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
  endtask

  initial begin
    int exp_sel;
    req = 4'd0;
    out_ready = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_model();
    rst_n = 1'b1;

    // Full load: one transfer per cycle, no bubbles.
    step(4'b1111, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(4'b1111, 1'b1);
`ifdef MUX_ARB_PRIO_EN
      exp_sel = 0;
`else
      exp_sel = i % 4;
`endif
      chk("full_load_sel", {30'd0, sel}, exp_sel);
      chk("full_load_valid", {31'd0, out_valid}, 32'd1);
    end
    chk("full_load_count", {24'd0, xfer_count}, 32'd8);
    step(4'b0000, 1'b1);

    // Async reset in the middle of a held grant on channel 2.
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    chk("pre_reset_sel", {30'd0, sel}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_grant", {28'd0, grant}, 32'd0);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sel", {30'd0, sel}, 32'd0);
    chk("reset_count", {24'd0, xfer_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001, 1'b0);
    chk("post_reset_sel", {30'd0, sel}, 32'd0);
    step(4'b0000, 1'b1);

    // Backpressure: selection held while out_ready is low.
    for (int i = 0; i < 5; i++) begin
      step(4'b0110, 1'b0);
      chk("bp_grant", {28'd0, grant}, 32'd2);
    end
    step(4'b0110, 1'b1);
    chk("bp_next_sel", {30'd0, sel}, 32'd2);

    // Wrap-around after channel 3, then drain to idle.
    step(4'b1000, 1'b1);
    step(4'b0101, 1'b1);
    chk("wrap_sel", {30'd0, sel}, 32'd0);
    step(4'b0101, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Request change during a held grant waits for the handshake.
    step(4'b0100, 1'b0);
    step(4'b0101, 1'b0);
    chk("held_sel", {30'd0, sel}, 32'd2);
    step(4'b0101, 1'b1);
    chk("after_hold_sel", {30'd0, sel}, 32'd0);
    step(4'b0000, 1'b1);

    // Counter wrap past 2^CNT_W - 1.
    for (int i = 0; i < 260; i++) step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);

    // Random traffic, including requests dropped before grant.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 nibble mux.
- Drives the mux's 2-bit sel from four request lines and presents the selection to the downstream consumer with a valid/ready handshake.
- Holds sel stable until the selected word is accepted, so the mux output is stable for the whole transfer.
- Counts completed transfers for debug.

Parameters:
CNT_W, 8, width of the transfer counter xfer_count (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  per-channel request; bit i = channel i (a,b,c,d) has data; held high until granted
grant  output  4  one-hot grant; bit i high while channel i is selected
sel  output  2  mux select, encoded index of grant; 00=a, 01=b, 10=c, 11=d
out_valid  output  1  selected mux word is valid for downstream
out_ready  input  1  downstream accepts word when out_valid & out_ready
xfer_count  output  CNT_W  number of completed transfers

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- All outputs are registered. There is no combinational path from req or out_ready to any output.
- Reset (rst_n low, takes effect immediately, independent of clk):
  - sel=2'b00, grant=4'b0000, out_valid=0, xfer_count=0.
  - Internal last-served pointer last=2'b11, so the first search starts at channel 0.
- Reset mid-transfer: the pending grant is dropped with no transfer counted. After release, the block is in IDLE.
- State machine: IDLE, GRANT.
- IDLE:
  - out_valid=0, grant=0; sel holds its last value.
  - If req != 0, the winner is the first set bit searching (last+1), (last+2), ... mod 4.
  - Next edge: sel=winner, grant=onehot(winner), out_valid=1, go to GRANT.
  - Latency from req rising to out_valid is 1 cycle.
- GRANT:
  - sel, grant and out_valid=1 are held stable while out_ready=0.
  - Changes on req, including deassertion of the granted bit, are ignored until the handshake. A protocol violation does not cause a glitch.
- Handshake (out_valid & out_ready at an edge):
  - last=sel and xfer_count=xfer_count+1, wrapping from 2^CNT_W-1 to 0.
  - Re-arbitration uses req sampled in the same cycle, searching from (sel+1) mod 4.
  - If any req remains: load the new winner and stay in GRANT with out_valid=1. This gives back-to-back transfers, one per cycle, with no bubble.
  - If req=0: out_valid=0, grant=0, go to IDLE.
- Fairness:
  - With all four requests held continuously, the grant order is 0,1,2,3,0,...
  - A single requester is re-granted every cycle.
- Wrap-around: the search from last=3 starts at channel 0; the search from last=2 tries 3 first, then 0.
- Simultaneous events:
  - A new req arriving in the same cycle as a handshake takes part in that arbitration.
  - A req arriving while GRANT is held (no handshake) waits.

Optional Feature:
- Macro: MUX_ARB_PRIO_EN.
- Defined:
  - Channel 0 (input a) has strict priority. Whenever req[0]=1 at an arbitration point (IDLE start or handshake), channel 0 wins regardless of last.
  - A held grant is never preempted.
  - For channels 1..3, the round-robin pointer continues as normal.
- Undefined: pure round-robin as described above; req[0] has no special treatment.

Test Plan:
- Reset: assert rst_n=0 mid-GRANT with sel=2 -> outputs go immediately to grant=0, out_valid=0, sel=0, xfer_count=0. After release with req=4'b0001, out_valid=1 one cycle later with sel=0.
- Full load: req=4'b1111 held, out_ready=1 for 8 cycles -> sel sequence 0,1,2,3,0,1,2,3, out_valid continuously 1, xfer_count=8.
- Backpressure: req=4'b0110, out_ready=0 for 5 cycles -> sel=1, grant=4'b0010, held 5 cycles. Raising out_ready for 1 cycle gives next sel=2, xfer_count=1.
- Wrap: after a transfer on ch3, req=4'b0101 -> next sel=0; after that, sel=2.
- Drain to idle: single req=4'b1000 dropped in the handshake cycle -> out_valid=0, grant=0 the next cycle, xfer_count incremented by 1. A counter preloaded to 255 with CNT_W=8 wraps to 0.
- With MUX_ARB_PRIO_EN: req=4'b1111, out_ready=1 -> sel stays 0 every cycle. With req=4'b1110 -> RR order 1,2,3. Toggling req[0] high during a held grant on ch2 with out_ready=0 -> no change until the handshake, then sel=0.
